// File: rtl/detect_event_collector.sv
// Collects one-cycle detector events from NUM_CH channels into a tagged FIFO with a pop-style read port.
// Optional macro COLLECTOR_DROP_CNT_EN enables the saturating lost-event counter on drop_cnt.
module detect_event_collector #(
  parameter int CH_W = 2,
  parameter int AW   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [(2**CH_W)-1:0]        det_valid,
  input  logic [32*(2**CH_W)-1:0]     det_time,
  output logic [(2**CH_W)-1:0]        det_ack,
  input  logic                        clr,
  input  logic                        rd_en,
  output logic                        rd_valid,
  output logic [31:0]                 rd_time,
  output logic [CH_W-1:0]             rd_ch,
  output logic                        empty,
  output logic                        full,
  output logic [AW:0]                 count,
  output logic                        drop,
  output logic [15:0]                 drop_cnt
);

  localparam int NUM_CH = 2**CH_W;
  localparam int DEPTH  = 2**AW;

  logic [31:0]        hold_r [NUM_CH];
  logic [NUM_CH-1:0]  pend_r;
  logic [NUM_CH-1:0]  grant_s;
  logic [NUM_CH-1:0]  drop_s;
  logic [CH_W-1:0]    rr_r;
  logic [CH_W-1:0]    gnt_idx_s;
  logic [CH_W-1:0]    cand_s;
  logic               gnt_any_s;
  logic               rd_fire_s;
  logic [CH_W+31:0]   mem_r [DEPTH];
  logic [AW:0]        wr_ptr_r;
  logic [AW:0]        rd_ptr_r;
  logic [AW:0]        wr_ptr_nxt_s;
  logic [AW:0]        rd_ptr_nxt_s;
  logic [AW:0]        count_nxt_s;

  // Round-robin arbiter over registered pend bits; full (registered count) blocks any grant.
  always_comb begin
    grant_s   = '0;
    gnt_idx_s = rr_r;
    gnt_any_s = 1'b0;
    cand_s    = rr_r;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand_s = rr_r + CH_W'(k);
      if (!full && !gnt_any_s && pend_r[cand_s]) begin
        gnt_any_s = 1'b1;
        gnt_idx_s = cand_s;
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
    if (gnt_any_s) begin
      grant_s[gnt_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // A channel loses an event only when its hold is still occupied and not being drained this cycle.
  always_comb begin
    drop_s       = det_valid & pend_r & ~grant_s;
    rd_fire_s    = rd_en & ~empty;
    wr_ptr_nxt_s = wr_ptr_r + {{AW{1'b0}}, gnt_any_s};
    rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, rd_fire_s};
    count_nxt_s  = wr_ptr_nxt_s - rd_ptr_nxt_s;
  end

  // Capture stage: hold registers, pending flags, acks, round-robin pointer and sticky drop.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pend_r  <= '0;
      det_ack <= '0;
      rr_r    <= CH_W'(NUM_CH - 1);
      drop    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        hold_r[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (det_valid[i] && (!pend_r[i] || grant_s[i])) begin
          hold_r[i]  <= det_time[32*i +: 32];
          pend_r[i]  <= 1'b1;
          det_ack[i] <= 1'b1;
        end else begin
          det_ack[i] <= 1'b0;
          if (grant_s[i]) begin
            pend_r[i] <= 1'b0;
          end
        end
      end
      if (gnt_any_s) begin
        rr_r <= gnt_idx_s;
      end
      if (|drop_s) begin
        drop <= 1'b1;
      end
    end
  end

  // FIFO storage; stale contents are harmless because the pointers are what reset clears.
  always_ff @(posedge clk) begin
    if (gnt_any_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {gnt_idx_s, hold_r[gnt_idx_s]};
    end
  end

  // FIFO pointers, registered status and the read port.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      rd_valid <= 1'b0;
      rd_time  <= 32'd0;
      rd_ch    <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count    <= count_nxt_s;
      empty    <= (count_nxt_s == '0);
      full     <= (count_nxt_s == (AW+1)'(DEPTH));
      rd_valid <= rd_fire_s;
      if (rd_fire_s) begin
        rd_time <= mem_r[rd_ptr_r[AW-1:0]][31:0];
        rd_ch   <= mem_r[rd_ptr_r[AW-1:0]][CH_W+31:32];
      end
    end
  end

`ifdef COLLECTOR_DROP_CNT_EN
  function automatic logic [CH_W:0] popcnt(input logic [NUM_CH-1:0] v);
    logic [CH_W:0] n;
    n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n = n + {{CH_W{1'b0}}, v[i]};
    end
    return n;
  endfunction

  logic [15:0] drop_cnt_r;
  logic [16:0] drop_sum_s;

  always_comb begin
    drop_sum_s = {1'b0, drop_cnt_r} + 17'(popcnt(drop_s));
  end

  // Lost-event counter, saturating so a long overflow never wraps back to small values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      drop_cnt_r <= 16'd0;
    end else if (drop_sum_s[16]) begin
      drop_cnt_r <= 16'hFFFF;
    end else begin
      drop_cnt_r <= drop_sum_s[15:0];
    end
  end

  assign drop_cnt = drop_cnt_r;
`else
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_detect_event_collector.sv
// Scoreboard bench for detect_event_collector: expected FIFO entries are queued at stimulus time
// and compared as rd_valid pulses appear; status outputs are checked against fixed expectations.
module tb_detect_event_collector;

  localparam int CH_W   = 2;
  localparam int AW     = 4;
  localparam int NUM_CH = 4;
`ifdef COLLECTOR_DROP_CNT_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif
  localparam int N_SAT = DC_EN ? 70000 : 100;

  logic                     clk;
  logic                     rst;
  logic [NUM_CH-1:0]        det_valid;
  logic [32*NUM_CH-1:0]     det_time;
  logic [NUM_CH-1:0]        det_ack;
  logic                     clr;
  logic                     rd_en;
  logic                     rd_valid;
  logic [31:0]              rd_time;
  logic [CH_W-1:0]          rd_ch;
  logic                     empty;
  logic                     full;
  logic [AW:0]              count;
  logic                     drop;
  logic [15:0]              drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [CH_W+31:0] sb [$];

  detect_event_collector #(.CH_W(CH_W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .det_valid(det_valid), .det_time(det_time), .det_ack(det_ack),
    .clr(clr), .rd_en(rd_en), .rd_valid(rd_valid), .rd_time(rd_time), .rd_ch(rd_ch),
    .empty(empty), .full(full), .count(count), .drop(drop), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; rd_en = 1'b0; det_valid = '0; det_time = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic set_time(input int ch, input logic [31:0] t);
    det_time[32*ch +: 32] = t;
  endtask

  // Stream n events on one channel, one per cycle, then one idle cycle so the last hold is written.
  task automatic fill(input int ch, input int n, input logic [31:0] base, input bit push);
    for (int k = 0; k < n; k++) begin
      det_valid = '0;
      det_valid[ch] = 1'b1;
      set_time(ch, base + 32'(k));
      if (push) sb.push_back({CH_W'(ch), base + 32'(k)});
      step();
    end
    det_valid = '0;
    step();
  endtask

  task automatic drain(input string tag);
    rd_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (empty) break;
      step();
    end
    rd_en = 1'b0;
    step();
    check({"drain_", tag}, 64'(sb.size()), 64'd0);
    check({"empty_after_", tag}, 64'(empty), 64'd1);
  endtask

  // Scoreboard consumer: every popped entry must match the next expected one.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        check("rd_entry", 64'({rd_ch, rd_time}), 64'(sb.pop_front()));
      end
    end
  end

  initial begin
    do_reset();
    check("rst_ack", 64'(det_ack), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_time", 64'(rd_time), 64'd0);
    check("rst_rd_ch", 64'(rd_ch), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_drop", 64'(drop), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);

    // Single event on ch2
    det_valid = 4'b0100; set_time(2, 32'h0000_1234);
    sb.push_back({2'd2, 32'h0000_1234});
    step();
    det_valid = '0;
    check("single_ack", 64'(det_ack), 64'h4);
    check("single_empty_t1", 64'(empty), 64'd1);
    step();
    check("single_ack_clear", 64'(det_ack), 64'd0);
    check("single_empty_t2", 64'(empty), 64'd0);
    check("single_count_t2", 64'(count), 64'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("single_rd_valid", 64'(rd_valid), 64'd1);
    check("single_rd_time", 64'(rd_time), 64'h1234);
    check("single_rd_ch", 64'(rd_ch), 64'd2);
    check("single_empty_t3", 64'(empty), 64'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("rd_empty_ignored", 64'(rd_valid), 64'd0);
    check("rd_time_hold", 64'(rd_time), 64'h1234);
    check("rd_ch_hold", 64'(rd_ch), 64'd2);
    check("count_after_empty_rd", 64'(count), 64'd0);

    // Simultaneous events on all channels after reset: round-robin from ch0
    do_reset();
    det_valid = 4'b1111;
    for (int c = 0; c < NUM_CH; c++) begin
      set_time(c, 32'(10 * (c + 1)));
      sb.push_back({CH_W'(c), 32'(10 * (c + 1))});
    end
    step();
    det_valid = '0;
    check("simul_ack", 64'(det_ack), 64'hF);
    repeat (4) step();
    check("simul_count", 64'(count), 64'd4);
    check("simul_full", 64'(full), 64'd0);
    drain("simul");

    // Full FIFO: held event, then drop
    do_reset();
    fill(0, 16, 32'd0, 1'b1);
    check("full_count", 64'(count), 64'd16);
    check("full_flag", 64'(full), 64'd1);
    det_valid = 4'b0001; set_time(0, 32'd1000);
    sb.push_back({2'd0, 32'd1000});
    step();
    check("full_hold_ack", 64'(det_ack), 64'h1);
    check("full_hold_count", 64'(count), 64'd16);
    set_time(0, 32'd2000);
    step();
    det_valid = '0;
    check("full_drop_ack", 64'(det_ack), 64'd0);
    check("full_drop", 64'(drop), 64'd1);
    check("full_drop_cnt", 64'(drop_cnt), DC_EN ? 64'd1 : 64'd0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("full_pop_count", 64'(count), 64'd15);
    step();
    check("full_refill_count", 64'(count), 64'd16);
    check("full_refill_flag", 64'(full), 64'd1);
    drain("full");
    check("drop_sticky", 64'(drop), 64'd1);

    // Grant plus recapture on ch1
    do_reset();
    det_valid = 4'b0010; set_time(1, 32'd5);
    sb.push_back({2'd1, 32'd5});
    step();
    set_time(1, 32'd6);
    sb.push_back({2'd1, 32'd6});
    step();
    det_valid = '0;
    check("recap_ack", 64'(det_ack), 64'h2);
    check("recap_no_drop", 64'(drop), 64'd0);
    step();
    check("recap_count", 64'(count), 64'd2);
    drain("recap");

    // Clear mid-operation
    do_reset();
    det_valid = 4'b0111;
    set_time(0, 32'd1); set_time(1, 32'd2); set_time(2, 32'd3);
    step();
    det_valid = 4'b0010; set_time(1, 32'd4);
    step();
    det_valid = '0;
    step(); step();
    check("clr_pre_count", 64'(count), 64'd3);
    check("clr_pre_drop", 64'(drop), 64'd1);
    check("clr_pre_drop_cnt", 64'(drop_cnt), DC_EN ? 64'd1 : 64'd0);
    clr = 1'b1; rd_en = 1'b1; det_valid = 4'b0001; set_time(0, 32'd99);
    step();
    clr = 1'b0; rd_en = 1'b0; det_valid = '0;
    check("clr_empty", 64'(empty), 64'd1);
    check("clr_count", 64'(count), 64'd0);
    check("clr_drop", 64'(drop), 64'd0);
    check("clr_drop_cnt", 64'(drop_cnt), 64'd0);
    check("clr_rd_valid", 64'(rd_valid), 64'd0);
    check("clr_ack", 64'(det_ack), 64'd0);
    step();
    check("clr_no_write", 64'(count), 64'd0);

    // Multi-channel drops and saturation while full
    do_reset();
    fill(3, 16, 32'd500, 1'b0);
    det_valid = 4'b1001; set_time(0, 32'd7); set_time(3, 32'd8);
    step();
    check("sat_hold_ack", 64'(det_ack), 64'h9);
    repeat (3) step();
    check("multi_drop_cnt", 64'(drop_cnt), DC_EN ? 64'd6 : 64'd0);
    det_valid = 4'b1000;
    repeat (N_SAT) step();
    check("sat_drop_cnt", 64'(drop_cnt), DC_EN ? 64'hFFFF : 64'd0);
    repeat (5) step();
    det_valid = '0;
    check("sat_stays", 64'(drop_cnt), DC_EN ? 64'hFFFF : 64'd0);
    check("sat_drop", 64'(drop), 64'd1);
    do_reset();
    check("sat_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    step();
    check("sb_final", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/detect_event_collector.md
Name: detect_event_collector

Overview:
- Consumer end of the per-microphone threshold detector interface.
- Captures the one-cycle `valid` / `detect_time` pulses from `NUM_CH` detector instances and returns a one-cycle ack per accepted event.
- Tags each event with its channel index and queues it in a FIFO.
- Exposes a simple read port for the processor-side register logic, which computes TDOA from the queued timestamps.

Parameters:
- CH_W, 2, channel index width; NUM_CH = 2**CH_W (localparam, default 4 channels).
- AW, 4, FIFO address width; DEPTH = 2**AW (localparam, default 16 entries).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- det_valid  input  NUM_CH  one-cycle event strobe per channel, bit i = channel i.
- det_time  input  32*NUM_CH  timestamp per channel, channel i at bits [32*i+31:32*i]; sampled only when det_valid[i]=1.
- det_ack  output  NUM_CH  one-cycle pulse, one cycle after an accepted event on channel i.
- clr  input  1  synchronous soft clear of FIFO, pending holds, flags and counter.
- rd_en  input  1  pop request.
- rd_valid  output  1  one-cycle pulse; rd_time / rd_ch are valid while it is high.
- rd_time  output  32  popped timestamp.
- rd_ch  output  CH_W  popped channel index.
- empty  output  1  FIFO empty.
- full  output  1  FIFO holds DEPTH entries.
- count  output  AW+1  number of entries in the FIFO.
- drop  output  1  sticky; set when any event is lost.
- drop_cnt  output  16  lost-event count (see Optional Feature).

Behaviour:
- Reset values: det_ack=0, rd_valid=0, rd_time=0, rd_ch=0, empty=1, full=0, count=0, drop=0, drop_cnt=0.
- Reset also clears all pend[i], hold[i], both FIFO pointers and the round-robin pointer (rr=NUM_CH-1).
- rst has priority over clr. clr produces the same state as rst in one cycle, and all other inputs are ignored that cycle.
- Capture stage, per channel i, one hold register hold[i] (32 bits) and flag pend[i]:
  - det_valid[i]=1 and (pend[i]=0 or channel i granted this cycle): hold[i]<=det_time[i], pend[i]<=1, det_ack[i]=1 next cycle.
  - det_valid[i]=1, pend[i]=1 and channel i not granted: event discarded, no ack, drop<=1, drop_cnt increments.
  - Granted and no new det_valid[i]: pend[i]<=0.
- Arbiter (combinational on registered pend):
  - Write is allowed when count<DEPTH. count is the registered value; a same-cycle pop does not free a slot.
  - If any pend[i]=1 and write is allowed: grant the first pending channel searching rr+1, rr+2, ... modulo NUM_CH; rr<=granted index.
  - Exactly one FIFO write per cycle, writing entry {i, hold[i]}.
  - If write is not allowed: no grant, pend bits hold, rr unchanged.
- FIFO:
  - wr_ptr/rd_ptr are AW+1 bits with natural wrap.
  - count = wr_ptr - rd_ptr; empty=(count==0); full=(count==DEPTH), all registered.
- Read:
  - rd_en=1 with empty=0: rd_ptr increments; next cycle rd_valid=1 and rd_time/rd_ch carry the entry.
  - rd_en=1 with empty=1: ignored, rd_valid=0, no state change.
  - Simultaneous read and write: both occur and count is unchanged.
- rd_time/rd_ch hold their last popped value when rd_valid=0.
- Latency: det_valid at cycle t -> pend at t+1 -> FIFO write at t+1 (if granted) -> empty=0 / count updated at t+2 -> rd_en at t+2 -> rd_valid at t+3.
- Ordering: FIFO order is grant order. Events on different channels in the same cycle enter in round-robin order, not timestamp order.
- Timestamps are stored unmodified; no arithmetic on det_time.

Optional Feature:
- Macro COLLECTOR_DROP_CNT_EN.
- Defined: drop_cnt is a 16-bit counter incremented once per discarded event, saturating at 16'hFFFF.
  - Several channels dropping in the same cycle add their popcount, saturated at 16'hFFFF.
  - Cleared by rst or clr.
- Undefined: no counter logic; drop_cnt tied to 16'd0. The drop sticky flag behaves identically in both builds.

Test Plan:
- Single event: det_valid[2]=1, det_time=32'h0000_1234 at t -> det_ack[2]=1 at t+1, empty=0 and count=1 at t+2; rd_en at t+2 -> rd_valid=1, rd_time=32'h1234, rd_ch=2 at t+3, then empty=1.
- Simultaneous: all 4 channels pulse together with times 10, 20, 30, 40 after reset (rr=3) -> 4 acks at t+1, FIFO writes on cycles t+1..t+4, reads return rd_ch 0, 1, 2, 3 with times 10, 20, 30, 40.
- Full: push 16 events with no reads -> full=1, count=16. A 17th event on ch0 is held (ack given, pend=1). A further ch0 event -> no ack, drop=1, drop_cnt=1 (macro on) / 0 (macro off). One rd_en -> pending entry written next cycle, count back to 16.
- Grant plus recapture: ch1 pending with time 5 and granted in the same cycle det_valid[1] brings time 6 -> no drop, ack issued, FIFO gets 5 then 6 in order.
- Clear mid-operation: 3 entries queued, drop=1, clr pulsed together with rd_en and det_valid[0] -> next cycle empty=1, count=0, drop=0, rd_valid=0, det_ack=0.
- Saturation (macro on): force 70000 drops on ch3 while the FIFO is full -> drop_cnt=16'hFFFF and stays there.
